booth_seq_divider: RTL and testbench
====================================

Name: booth_seq_divider

Overview:
- Sequential signed integer divider; the inverse operation of the combinational 8-bit signed Booth multiplier in the arithmetic datapath.
- Accepts a signed dividend/divisor pair over a valid/ready handshake.
- Computes quotient and remainder by iterative restoring division on magnitudes, one quotient bit per clock, then applies sign correction.
- Returns the result over a second valid/ready handshake, so it can sit in the same datapath as the multiplier.

Parameters:
- WIDTH, 8, operand/result width in bits, two's complement; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  signed dividend.
- divisor  input  WIDTH  signed divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- div_by_zero  output  1  result came from divisor == 0.
- overflow  output  1  result came from most-negative / -1.

Behaviour:
- Reset: single clock (clk), asynchronous active-low reset (rst_n). Asserting rst_n=0 forces immediately:
  - state=IDLE, in_ready=1, out_valid=0;
  - quotient=0, remainder=0, div_by_zero=0, overflow=0;
  - iteration counter=0.
  - This applies mid-operation too: any in-flight division is discarded and no out_valid follows.
- States: IDLE, CALC, FIX, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, accept edge (in_valid & in_ready):
  - Latch |dividend| and |divisor| as WIDTH-bit unsigned magnitudes (most-negative maps to 2^(WIDTH-1), which fits).
  - Latch sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - Clear partial remainder (WIDTH+1 bits) and counter.
  - If divisor==0, go to DONE with quotient=all ones (-1), remainder=dividend, div_by_zero=1, overflow=0. Else go to CALC.
- CALC, one restoring step per edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - After WIDTH steps (counter == WIDTH-1 on that edge), go to FIX.
- FIX, one edge:
  - quotient = sign_q ? -qmag : qmag, truncated to WIDTH.
  - remainder = sign_r ? -rmag : rmag.
  - overflow=1 iff dividend was most-negative and divisor == -1; quotient then wraps to most-negative and remainder=0.
  - Go to DONE.
- DONE:
  - Outputs held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE: out_valid=0, in_ready=1. quotient/remainder/flags keep their last values.
- No accept is possible in DONE or in the same cycle as the output handshake; a new operand pair is accepted at the earliest one cycle later.
- Latency, accept edge N (nonzero divisor): CALC covers edges N+1..N+WIDTH, FIX is edge N+WIDTH+1, out_valid rises after edge N+WIDTH+1 (9 edges for WIDTH=8).
- Latency, divide-by-zero: out_valid rises after edge N.
- Throughput with out_ready tied high: one result per WIDTH+3 cycles.
- Exact results: zero dividend gives q=0, r=0 in full latency. |dividend| < |divisor| gives q=0, r=dividend.
- Inputs are ignored outside IDLE. in_valid may drop without consequence while in_ready=0.

Decomposition:
- Shared package booth_arith_pkg:
  - state enum {IDLE, CALC, FIX, DONE};
  - localparam ITER = WIDTH;
  - counter width = $clog2(WIDTH)+1;
  - function for two's-complement magnitude.
- One sub-module: div_restore_step, combinational. Inputs: partial remainder, next dividend bit, divisor magnitude. Outputs: new partial remainder, quotient bit.
- The top module holds the FSM, registers and sign fix.

Test Plan:
- 100 / 7 -> out_valid after 9 edges; quotient=8'h0E (14), remainder=8'h02, flags 0.
- -100 / 7 -> quotient=8'hF2 (-14), remainder=8'hFE (-2). Then 100 / -7 -> quotient=8'hF2, remainder=8'h02.
- 7 / 0 -> out_valid one cycle after accept; quotient=8'hFF, remainder=8'h07, div_by_zero=1.
- -128 / -1 -> quotient=8'h80, remainder=8'h00, overflow=1. Separately, -128 / 1 -> quotient=8'h80, overflow=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Release -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 on the 4th CALC cycle -> outputs cleared immediately, no out_valid. After release, 50 / -3 -> quotient=8'hF0 (-16), remainder=8'h02.

Source files
------------

// File: rtl/booth_arith_pkg.sv
// Shared arithmetic definitions for the sequential signed divider.
package booth_arith_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned ITER      = DEF_WIDTH;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_t;

  // Unsigned magnitude of a width-bit two's-complement value held in the low bits.
  // The most-negative value maps to 2^(width-1), which still fits in width bits.
  function automatic logic [63:0] twos_mag(input logic [63:0] value, input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    if (value[width-1]) begin
      twos_mag = (~value + 64'd1) & mask;
    end else begin
      twos_mag = value & mask;
    end
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] dsr_mag,
  output logic [WIDTH:0]   new_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Keep the trial difference when non-negative, otherwise restore the shifted remainder.
  always_comb begin
    shifted = {part_rem, next_bit};
    trial   = shifted - {2'b00, dsr_mag};
    q_bit   = ~trial[WIDTH+1];
    new_rem = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: magnitude restoring division, one quotient bit per clock,
// followed by a sign-fix cycle. Valid/ready handshakes on both operand and result sides.
module booth_seq_divider
  import booth_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned      CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] qmag_q;      // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_quo_q, neg_rem_q, ovf_pend_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             div_by_zero_q, overflow_q;

  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic             dsr_zero, ovf_in;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign dvd_mag  = WIDTH'(twos_mag(64'(dividend), WIDTH));
  assign dsr_mag  = WIDTH'(twos_mag(64'(divisor), WIDTH));
  assign dsr_zero = (divisor == '0);
  assign ovf_in   = (dividend == MostNeg) && (divisor == '1);

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .part_rem(rem_q),
    .next_bit(qmag_q[WIDTH-1]),
    .dsr_mag (dsr_q),
    .new_rem (step_rem),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = dsr_zero ? StDone : StCalc;
      end
      StCalc: if (cnt_q == LastCnt) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qmag_q        <= '0;
      dsr_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      ovf_pend_q    <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            qmag_q     <= dvd_mag;
            dsr_q      <= dsr_mag;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q  <= dividend[WIDTH-1];
            ovf_pend_q <= ovf_in;
            if (dsr_zero) begin
              quotient_q    <= '1;
              remainder_q   <= dividend;
              div_by_zero_q <= 1'b1;
              overflow_q    <= 1'b0;
            end
          end
        end
        StCalc: begin
          qmag_q <= {qmag_q[WIDTH-2:0], step_q};
          rem_q  <= step_rem;
          cnt_q  <= cnt_q + CntW'(1);
        end
        StFix: begin
          div_by_zero_q <= 1'b0;
          overflow_q    <= ovf_pend_q;
          if (ovf_pend_q) begin
            quotient_q  <= MostNeg;
            remainder_q <= '0;
          end else begin
            quotient_q  <= neg_quo_q ? -qmag_q : qmag_q;
            remainder_q <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed self-checking bench for booth_seq_divider (WIDTH = 8).
module tb_booth_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  booth_seq_divider #(
    .WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Present an operand pair, let it be accepted, then wait for out_valid.
  // lat counts clock edges after the accept edge; -1 means the budget expired.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    n_checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_out: q=%h r=%h dbz=%b ovf=%b, required all zero", quotient,
               remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_basic();
    int lat;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: in_ready=%b, required 1", in_ready);
    end
    run_op(8'd100, 8'd7, lat);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: %0d edges, required 9", lat);
    end
    n_checks++;
    if (quotient !== 8'h0E || remainder !== 8'h02 || div_by_zero !== 1'b0 || overflow !== 1'b0)
    begin
      n_fail++;
      $display("FAIL basic_100_7: q=%h r=%h dbz=%b ovf=%b, required 0e/02/0/0", quotient,
               remainder, div_by_zero, overflow);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: in_ready=%b in DONE, required 0", in_ready);
    end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'h0E) begin
      n_fail++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b q=%h, required 0/1/0e", out_valid,
               in_ready, quotient);
    end
  endtask

  task automatic test_signs();
    int lat;
    run_op(8'h9C, 8'd7, lat);  // -100 / 7
    n_checks++;
    if (lat !== 9 || quotient !== 8'hF2 || remainder !== 8'hFE) begin
      n_fail++;
      $display("FAIL neg_dividend: lat=%0d q=%h r=%h, required 9/f2/fe", lat, quotient,
               remainder);
    end
    release_out();
    run_op(8'd100, 8'hF9, lat);  // 100 / -7
    n_checks++;
    if (lat !== 9 || quotient !== 8'hF2 || remainder !== 8'h02) begin
      n_fail++;
      $display("FAIL neg_divisor: lat=%0d q=%h r=%h, required 9/f2/02", lat, quotient,
               remainder);
    end
    release_out();
    run_op(8'hF3, 8'hFB, lat);  // -13 / -5 -> 2 rem -3
    n_checks++;
    if (quotient !== 8'h02 || remainder !== 8'hFD) begin
      n_fail++;
      $display("FAIL both_neg: q=%h r=%h, required 02/fd", quotient, remainder);
    end
    release_out();
    run_op(8'd0, 8'd9, lat);
    n_checks++;
    if (lat !== 9 || quotient !== 8'h00 || remainder !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_dividend: lat=%0d q=%h r=%h, required 9/00/00", lat, quotient,
               remainder);
    end
    release_out();
    run_op(8'hFD, 8'd5, lat);  // -3 / 5 -> 0 rem -3
    n_checks++;
    if (quotient !== 8'h00 || remainder !== 8'hFD) begin
      n_fail++;
      $display("FAIL small_dividend: q=%h r=%h, required 00/fd", quotient, remainder);
    end
    release_out();
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(8'd7, 8'd0, lat);
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL dbz_latency: %0d edges after accept, required 0", lat);
    end
    n_checks++;
    if (quotient !== 8'hFF || remainder !== 8'h07 || div_by_zero !== 1'b1 || overflow !== 1'b0)
    begin
      n_fail++;
      $display("FAIL dbz_result: q=%h r=%h dbz=%b ovf=%b, required ff/07/1/0", quotient,
               remainder, div_by_zero, overflow);
    end
    release_out();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(8'h80, 8'hFF, lat);  // -128 / -1
    n_checks++;
    if (lat !== 9 || quotient !== 8'h80 || remainder !== 8'h00 || overflow !== 1'b1 ||
        div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_result: lat=%0d q=%h r=%h ovf=%b dbz=%b, required 9/80/00/1/0", lat,
               quotient, remainder, overflow, div_by_zero);
    end
    release_out();
    run_op(8'h80, 8'h01, lat);  // -128 / 1
    n_checks++;
    if (quotient !== 8'h80 || remainder !== 8'h00 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL most_neg_by_one: q=%h r=%h ovf=%b, required 80/00/0", quotient, remainder,
               overflow);
    end
    release_out();
  endtask

  task automatic test_back_pressure();
    int lat;
    int bad = 0;
    run_op(8'd25, 8'd4, lat);
    n_checks++;
    if (lat !== 9 || quotient !== 8'h06 || remainder !== 8'h01) begin
      n_fail++;
      $display("FAIL bp_result: lat=%0d q=%h r=%h, required 9/06/01", lat, quotient, remainder);
    end
    dividend = 8'd9;
    divisor  = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'h06 ||
          remainder !== 8'h01) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    release_out();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'h06) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b q=%h, required 1/0/06", in_ready,
               out_valid, quotient);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ignored: in_ready=%b, required 1 (held input was not accepted)",
               in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {quotient, remainder, div_by_zero, overflow} !== 18'd0) begin
      n_fail++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b q=%h r=%h, required 1/0/00/00",
               in_ready, out_valid, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_no_result: out_valid seen %0d cycles, required 0", seen);
    end
    run_op(8'd50, 8'hFD, lat);  // 50 / -3
    n_checks++;
    if (lat !== 9 || quotient !== 8'hF0 || remainder !== 8'h02) begin
      n_fail++;
      $display("FAIL after_reset: lat=%0d q=%h r=%h, required 9/f0/02", lat, quotient,
               remainder);
    end
    release_out();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_back_pressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
